muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit for the Execute stage; a parametrised successor to the execute-stage ALU decode.
- It decodes funct for R-type instructions with the M-extension bit set, then runs a multi-cycle shift-add multiply or restoring divide.
- It uses a valid/ready handshake on both sides; the 4-stage pipeline stalls on in_ready/out_valid and flushes through kill.

Parameters:
- WIDTH, 32, operand/result width; even, >= 8.
- MUL_STEP, 1, multiplier bits retired per cycle; one of 1, 2, 4; must divide WIDTH.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  request valid.
- in_ready  output  1  unit can accept a request.
- opcode  input  7  instruction opcode.
- funct  input  3  funct3.
- m_ext  input  1  instruction bit 25 (funct7 = 0000001).
- op_a  input  WIDTH  rs1 value.
- op_b  input  WIDTH  rs2 value.
- kill  input  1  flush the in-flight operation.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer takes the result.
- result  output  WIDTH  selected result.
- busy  output  1  state is not IDLE.

Behaviour:
- Reset: state=IDLE, out_valid=0, result=0, busy=0, in_ready=0 while rst is high and 1 in the first cycle after.
- States: IDLE, MUL, DIV, FIX, DONE.
- in_ready = (state==IDLE) & ~rst.
- Accept condition: in_valid & in_ready & opcode==OPC_ARI_RTYPE & m_ext. A request failing this check is ignored and the state stays IDLE.
- On accept, latch funct and operand magnitudes, and record the result sign:
  - MUL, MULH: both operands signed.
  - MULHSU: op_a signed, op_b unsigned.
  - MULHU, DIVU, REMU: both unsigned.
  - DIV: quotient sign = sign(a) xor sign(b). REM: remainder sign = sign(a).
- Special divide cases go IDLE -> DONE on the accept edge:
  - Divisor 0: DIV/DIVU return all ones; REM/REMU return op_a.
  - Signed overflow (op_a = most negative, op_b = all ones): DIV returns op_a; REM returns 0.
- MUL path: 2*WIDTH-bit accumulator; one step per edge retires MUL_STEP multiplier bits. After WIDTH/MUL_STEP steps -> FIX.
- DIV path: one restoring step per edge for WIDTH steps -> FIX.
- FIX: apply two's-complement negation if the recorded sign requires it, select the output, then -> DONE.
  - MUL selects the low half; MULH/MULHSU/MULHU select the high half.
  - DIV/DIVU select the quotient; REM/REMU select the remainder.
- Latency: out_valid rises N+1 edges after the accepting edge, where N = WIDTH/MUL_STEP (mul) or WIDTH (div). Special cases take 1 edge.
- DONE: out_valid=1 and result is held stable until out_ready. The edge with out_ready=1 -> IDLE and out_valid=0. There is no accept in that same edge; the next accept is possible one cycle later.
- kill: highest priority after rst. Next state is IDLE and out_valid=0, from any state. kill together with in_valid in IDLE causes no accept.
- rst mid-operation: returns to the reset values with no residual output.
- The step counter is log2(WIDTH)+1 bits. It is cleared on accept and never wraps within an operation.
- Arithmetic is unsigned internally. Signed operands are converted to magnitude at accept, so the most-negative magnitude (2^(WIDTH-1)) must fit the WIDTH-bit unsigned register.

Decomposition:
- Add to the shared Opcode.vh header: FNC7_MEXT, FNC_MUL, FNC_MULH, FNC_MULHSU, FNC_MULHU, FNC_DIV, FNC_DIVU, FNC_REM, FNC_REMU.
- Add the state encodings to a new MulDiv.vh header.
- One combinational sub-module, muldiv_div_step: WIDTH-bit restoring subtract/shift step (remainder, quotient, divisor in -> remainder, quotient out).

Test Plan:
- MUL, op_a=7, op_b=0xFFFFFFFD (WIDTH=32, MUL_STEP=1) -> result 0xFFFFFFEB; out_valid first high 33 edges after accept.
- MULH, 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; repeat with MUL_STEP=4 -> out_valid after 9 edges.
- DIVU 100/7 -> 14 and REMU -> 2; DIV 0xFFFFFF9C/7 -> 0xFFFFFFF2 and REM -> 0xFFFFFFFE; latency 33 edges.
- Divide by zero: DIV 5/0 -> 0xFFFFFFFF, REM 5/0 -> 5. Overflow: DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0. Each valid after 1 edge.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> result and out_valid stable, in_ready=0. out_ready=1 -> IDLE next edge.
- Assert kill at step 10 of a DIV -> IDLE next edge, out_valid never high. Non-M opcode with in_valid=1 -> no accept, busy=0. Assert rst mid-MUL -> all outputs at reset values.

Source files
------------

// File: rtl/muldiv_unit_pkg.sv
// Shared constants for the iterative RV32M multiply/divide unit.
// Opcode/funct encodings, FSM state encodings and operand-sign helpers.
package muldiv_unit_pkg;

    localparam logic [6:0] OPC_ARI_RTYPE = 7'b0110011;
    localparam logic [6:0] FNC7_MEXT     = 7'b0000001;

    localparam logic [2:0] FNC_MUL    = 3'b000;
    localparam logic [2:0] FNC_MULH   = 3'b001;
    localparam logic [2:0] FNC_MULHSU = 3'b010;
    localparam logic [2:0] FNC_MULHU  = 3'b011;
    localparam logic [2:0] FNC_DIV    = 3'b100;
    localparam logic [2:0] FNC_DIVU   = 3'b101;
    localparam logic [2:0] FNC_REM    = 3'b110;
    localparam logic [2:0] FNC_REMU   = 3'b111;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_MUL  = 3'd1;
    localparam logic [2:0] S_DIV  = 3'd2;
    localparam logic [2:0] S_FIX  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    // rs1 is treated as signed for these operations
    function automatic logic a_signed(input logic [2:0] f);
        return f inside {FNC_MUL, FNC_MULH, FNC_MULHSU, FNC_DIV, FNC_REM};
    endfunction

    // rs2 is treated as signed for these operations
    function automatic logic b_signed(input logic [2:0] f);
        return f inside {FNC_MUL, FNC_MULH, FNC_DIV, FNC_REM};
    endfunction

endpackage

// File: rtl/muldiv_div_step.sv
// One restoring-division step on unsigned magnitudes.
// Shifts the next dividend bit into the remainder and trial-subtracts.
module muldiv_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] dvs_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH:0] shf;
    logic [WIDTH:0] dif;

    // remainder < divisor always holds, so the top bit of dif is the borrow
    assign shf   = {rem_i, quo_i[WIDTH-1]};
    assign dif   = shf - {1'b0, dvs_i};
    assign rem_o = dif[WIDTH] ? shf[WIDTH-1:0] : dif[WIDTH-1:0];
    assign quo_o = {quo_i[WIDTH-2:0], ~dif[WIDTH]};

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the Execute stage.
// Shift-add multiply, restoring divide, sign fix-up, valid/ready on both sides.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MUL_STEP = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct,
    input  logic             m_ext,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             kill,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             busy
);

    localparam int CW    = $clog2(WIDTH) + 1;
    localparam int MUL_N = WIDTH / MUL_STEP;
    localparam logic [CW-1:0] MUL_LAST = CW'(MUL_N - 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH - 1);

    logic [2:0]         state_q, state_d;
    logic [2:0]         fn_q, fn_d;
    logic               neg_q, neg_d;
    logic [WIDTH-1:0]   opr_q, opr_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   result_q, result_d;

    logic               accept;
    logic               sa, sb;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic               div_zero, ovf;
    logic [WIDTH-1:0]   special;

    logic [WIDTH+MUL_STEP-1:0] mul_sum;
    logic [2*WIDTH-1:0]        mul_next;
    logic [WIDTH-1:0]          drem, dquo;

    logic [2*WIDTH-1:0] mul_full;
    logic [WIDTH-1:0]   div_sel;
    logic [WIDTH-1:0]   div_val;
    logic [WIDTH-1:0]   fix_val;

    assign in_ready  = (state_q == S_IDLE) & ~rst;
    assign busy      = (state_q != S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign result    = result_q;

    assign accept = in_valid & in_ready & m_ext
                  & (opcode == OPC_ARI_RTYPE);

    // operands become magnitudes; the most-negative value maps onto itself
    assign sa    = a_signed(funct) & op_a[WIDTH-1];
    assign sb    = b_signed(funct) & op_b[WIDTH-1];
    assign mag_a = sa ? -op_a : op_a;
    assign mag_b = sb ? -op_b : op_b;

    assign div_zero = (op_b == '0);
    assign ovf      = (funct == FNC_DIV || funct == FNC_REM)
                    && (op_a == {1'b1, {(WIDTH-1){1'b0}}})
                    && (op_b == '1);

    // funct[1] separates REM/REMU from DIV/DIVU
    assign special = div_zero ? (funct[1] ? op_a : '1)
                              : (funct[1] ? '0 : op_a);

    // retire MUL_STEP multiplier bits from the low half into the high half
    always_comb begin
        mul_sum = {{MUL_STEP{1'b0}}, acc_q[2*WIDTH-1:WIDTH]};
        for (int j = 0; j < MUL_STEP; j++) begin
            if (acc_q[j]) begin
                mul_sum = mul_sum + ({{MUL_STEP{1'b0}}, opr_q} << j);
            end
        end
    end

    assign mul_next = {mul_sum, acc_q[WIDTH-1:MUL_STEP]};

    muldiv_div_step #(
        .WIDTH (WIDTH)
    ) u_div_step (
        .rem_i (acc_q[2*WIDTH-1:WIDTH]),
        .quo_i (acc_q[WIDTH-1:0]),
        .dvs_i (opr_q),
        .rem_o (drem),
        .quo_o (dquo)
    );

    // sign fix-up and output selection
    always_comb begin
        mul_full = neg_q ? -acc_q : acc_q;
        div_sel  = fn_q[1] ? acc_q[2*WIDTH-1:WIDTH] : acc_q[WIDTH-1:0];
        div_val  = neg_q ? -div_sel : div_sel;
        if (fn_q[2]) begin
            fix_val = div_val;
        end else if (fn_q == FNC_MUL) begin
            fix_val = mul_full[WIDTH-1:0];
        end else begin
            fix_val = mul_full[2*WIDTH-1:WIDTH];
        end
    end

    // next-state logic; kill overrides everything but reset
    always_comb begin
        state_d  = state_q;
        fn_d     = fn_q;
        neg_d    = neg_q;
        opr_d    = opr_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        if (kill) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        fn_d  = funct;
                        neg_d = (funct == FNC_REM) ? sa : (sa ^ sb);
                        cnt_d = '0;
                        if (funct[2] && (div_zero || ovf)) begin
                            result_d = special;
                            state_d  = S_DONE;
                        end else if (funct[2]) begin
                            opr_d   = mag_b;
                            acc_d   = {{WIDTH{1'b0}}, mag_a};
                            state_d = S_DIV;
                        end else begin
                            opr_d   = mag_a;
                            acc_d   = {{WIDTH{1'b0}}, mag_b};
                            state_d = S_MUL;
                        end
                    end
                end
                S_MUL: begin
                    acc_d = mul_next;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == MUL_LAST) state_d = S_FIX;
                end
                S_DIV: begin
                    acc_d = {drem, dquo};
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == DIV_LAST) state_d = S_FIX;
                end
                S_FIX: begin
                    result_d = fix_val;
                    state_d  = S_DONE;
                end
                S_DONE: begin
                    if (out_ready) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            fn_q     <= '0;
            neg_q    <= 1'b0;
            opr_q    <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            fn_q     <= fn_d;
            neg_q    <= neg_d;
            opr_q    <= opr_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M cases, handshake,
// kill/reset behaviour and random operations against a 64-bit model.
module tb_muldiv_unit;

    localparam int W     = 32;
    localparam int MSTEP = 1;
    localparam logic [6:0] OPC_R = 7'b0110011;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [6:0]   opcode;
    logic [2:0]   funct;
    logic         m_ext;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         kill;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         busy;

    int n_chk  = 0;
    int n_fail = 0;

    muldiv_unit #(
        .WIDTH    (W),
        .MUL_STEP (MSTEP)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .funct     (funct),
        .m_ext     (m_ext),
        .op_a      (op_a),
        .op_b      (op_b),
        .kill      (kill),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic is_ovf(input logic [2:0] f,
                                    input logic [31:0] a,
                                    input logic [31:0] b);
        return (f == 3'd4 || f == 3'd6) && a == 32'h8000_0000
               && b == 32'hFFFF_FFFF;
    endfunction

    // RV32M semantics from plain 64-bit arithmetic
    function automatic logic [31:0] ref_res(input logic [2:0] f,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        longint     sa, sb, ub, q;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'b0, b});
        p  = '0;
        q  = 0;
        case (f)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (is_ovf(f, a, b)) return a;
                q = sa / sb;
                return q[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (is_ovf(f, a, b)) return 32'h0;
                q = sa % sb;
                return q[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // edges after the accepting edge until out_valid is seen
    function automatic int exp_lat(input logic [2:0] f,
                                   input logic [31:0] a,
                                   input logic [31:0] b);
        if (f[2] && (b == 0 || is_ovf(f, a, b))) return 0;
        return (f[2] ? W : W / MSTEP) + 1;
    endfunction

    // issue one request, wait for the result, check it, drain it
    task automatic do_op(input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp,
                         input string tag);
        int n;
        in_valid = 1'b1;
        opcode   = OPC_R;
        m_ext    = 1'b1;
        funct    = f;
        op_a     = a;
        op_b     = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq({tag, " lat"}, n, exp_lat(f, a, b));
        check_eq({tag, " res"}, result, exp);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_eq({tag, " drain"}, {31'b0, out_valid}, 32'd0);
    endtask

    initial begin
        int n;
        logic seen;
        logic [2:0]  rf;
        logic [31:0] ra, rb;

        rst = 1'b1; in_valid = 1'b0; opcode = '0; funct = '0;
        m_ext = 1'b0; op_a = '0; op_b = '0; kill = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst in_ready", {31'b0, in_ready}, 32'd0);
        check_eq("rst busy", {31'b0, busy}, 32'd0);
        check_eq("rst out_valid", {31'b0, out_valid}, 32'd0);
        check_eq("rst result", result, 32'd0);
        rst = 1'b0;
        #1;
        check_eq("post rst in_ready", {31'b0, in_ready}, 32'd1);

        do_op(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul");
        do_op(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "mulh");
        do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu");
        do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu");
        do_op(3'd5, 32'd100, 32'd7, 32'd14, "divu");
        do_op(3'd7, 32'd100, 32'd7, 32'd2, "remu");
        do_op(3'd4, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, "div");
        do_op(3'd6, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, "rem");
        do_op(3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, "div0");
        do_op(3'd6, 32'd5, 32'd0, 32'd5, "rem0");
        do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "divovf");
        do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, "removf");

        // backpressure with a second request already waiting
        in_valid = 1'b1; opcode = OPC_R; m_ext = 1'b1;
        funct = 3'd5; op_a = 32'd100; op_b = 32'd7;
        @(posedge clk); #1;
        funct = 3'd0; op_a = 32'd3; op_b = 32'd7;
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("bp lat", n, 33);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check_eq("bp valid", {31'b0, out_valid}, 32'd1);
            check_eq("bp result", result, 32'd14);
            check_eq("bp in_ready", {31'b0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_eq("bp idle", {31'b0, busy}, 32'd0);
        check_eq("bp no valid", {31'b0, out_valid}, 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_eq("bp next accept", {31'b0, busy}, 32'd1);
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("bp2 result", result, 32'd21);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // kill in the middle of a divide
        in_valid = 1'b1; funct = 3'd4; op_a = 32'd1000; op_b = 32'd3;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        check_eq("kill busy", {31'b0, busy}, 32'd0);
        check_eq("kill in_ready", {31'b0, in_ready}, 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        check_eq("kill no valid", {31'b0, seen}, 32'd0);

        // kill alongside a request in IDLE
        kill = 1'b1; in_valid = 1'b1; funct = 3'd0;
        @(posedge clk); #1;
        kill = 1'b0; in_valid = 1'b0;
        check_eq("kill+req busy", {31'b0, busy}, 32'd0);

        // non-M requests are ignored
        in_valid = 1'b1; opcode = 7'b0010011; m_ext = 1'b1;
        @(posedge clk); #1;
        check_eq("non-R busy", {31'b0, busy}, 32'd0);
        opcode = OPC_R; m_ext = 1'b0;
        @(posedge clk); #1;
        check_eq("no mext busy", {31'b0, busy}, 32'd0);
        in_valid = 1'b0; m_ext = 1'b1;

        // reset in the middle of a multiply
        in_valid = 1'b1; funct = 3'd0; op_a = 32'd9; op_b = 32'd9;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check_eq("mid rst busy", {31'b0, busy}, 32'd0);
        check_eq("mid rst valid", {31'b0, out_valid}, 32'd0);
        check_eq("mid rst result", result, 32'd0);
        check_eq("mid rst in_ready", {31'b0, in_ready}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check_eq("mid rst release", {31'b0, in_ready}, 32'd1);

        // random operations against the reference model
        for (int i = 0; i < 40; i++) begin
            rf = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = 32'($urandom_range(1, 20));
                3: ra = 32'h8000_0000;
                default: ;
            endcase
            do_op(rf, ra, rb, ref_res(rf, ra, rb), "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
